// File: rtl/config_chain_loader_if.sv
// rtl/config_chain_loader_if.sv - host byte stream, readback and programming-chain signals of the loader
interface config_chain_loader_if;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       prog_in;
    logic       prog_clk;
    logic       prog_en;
    logic       prog_out;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, byte_in, byte_valid, prog_out,
        input  byte_ready, prog_in, prog_clk, prog_en, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  start, byte_in, byte_valid, prog_out,
        output byte_ready, prog_in, prog_clk, prog_en, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - byte-fed serial configuration chain loader with prog_out readback
module config_chain_loader #(
    parameter int CHAIN_LEN = 175,
    parameter int DIV       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    config_chain_loader_if.slave bus
);
    localparam int              BCW     = $clog2(CHAIN_LEN + 1);
    localparam logic [7:0]      PH_LAST = 8'(DIV - 1);
    localparam logic [BCW-1:0]  BC_LAST = BCW'(CHAIN_LEN);

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     phase;
    logic [BCW-1:0] bit_count;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     rd_shift;
    logic           phase_end;
    logic           chain_full;
    logic           byte_end;

    assign phase_end  = (phase == PH_LAST);
    assign chain_full = (bit_count == BC_LAST);
    assign byte_end   = (bit_idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   if (bus.byte_valid) state_nxt = LOW;
            LOW:     if (phase_end) state_nxt = HIGH;
            HIGH: begin
                if (phase_end) begin
                    if (chain_full)    state_nxt = DONE;
                    else if (byte_end) state_nxt = FETCH;
                    else               state_nxt = LOW;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.prog_clk   = 1'b0;
        bus.prog_en    = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            FETCH: begin
                bus.byte_ready = 1'b1;
                bus.prog_en    = 1'b1;
                bus.busy       = 1'b1;
            end
            LOW: begin
                bus.prog_en = 1'b1;
                bus.busy    = 1'b1;
            end
            HIGH: begin
                bus.prog_clk = 1'b1;
                bus.prog_en  = 1'b1;
                bus.busy     = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: prog_in only moves on entry to LOW, so the chain sees a stable bit across the whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= 8'd0;
            bit_count    <= '0;
            bit_idx      <= 3'd0;
            shreg        <= 8'd0;
            rd_shift     <= 8'd0;
            bus.prog_in  <= 1'b0;
            bus.rd_data  <= 8'd0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            phase <= ((state == LOW || state == HIGH) && !phase_end) ? phase + 8'd1 : 8'd0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bit_count <= '0;
                        bit_idx   <= 3'd0;
                    end
                end
                FETCH: begin
                    if (bus.byte_valid) begin
                        shreg       <= bus.byte_in;
                        bus.prog_in <= bus.byte_in[0];
                        bit_idx     <= 3'd0;
                        rd_shift    <= 8'd0;
                    end
                end
                LOW: begin
                    // The bit about to fall off the chain end is captured just before the rising edge.
                    if (phase_end) begin
                        rd_shift[bit_idx] <= bus.prog_out;
                        bit_count         <= bit_count + BCW'(1);
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (chain_full || byte_end) begin
                            bus.rd_valid <= 1'b1;
                            bus.rd_data  <= rd_shift;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            bus.prog_in <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - scoreboard bench for config_chain_loader with a serial chain model
module tb_config_chain_loader;
    localparam int CL = 175;
    localparam int NB = (CL + 7) / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    config_chain_loader_if bus();

    config_chain_loader #(.CHAIN_LEN(CL), .DIV(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream chain: shifts on prog_clk rising edge, newest bit at index 0.
    logic [CL-1:0] chain = '0;
    assign bus.prog_out = chain[CL-1];
    always @(posedge bus.prog_clk) chain <= {chain[CL-2:0], bus.prog_in};

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         busy_tot = 0, edge_tot = 0, done_tot = 0, acc_tot = 0;
    logic       pc_q = 1'b0;
    logic [7:0] prev_pat = 8'h00;
    bit         prev_known = 1'b1;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CL-1:0] pat_chain(input logic [7:0] p);
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[CL-1-i] = p[i % 8];
        return v;
    endfunction

    always @(negedge clk) begin
        if (bus.busy) busy_tot++;
        if (bus.prog_clk && !pc_q) edge_tot++;
        pc_q = bus.prog_clk;
        if (bus.byte_ready && bus.byte_valid) acc_tot++;
        if (bus.done) begin
            done_tot++;
            check("done_prog_en", bus.prog_en, 1'b0);
        end
        if (bus.rd_valid) begin
            check("rd_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q.pop_front());
        end
    end

    task automatic push_expected();
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (8 * k + j < CL) b[j] = prev_known ? prev_pat[j] : chain[CL-1-(8*k+j)];
                else                b[j] = 1'b0;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] pat, input int stall_k, input bit extra_start,
                            input int exp_busy);
        int b0, e0, d0, a0, cyc, tmo;
        tmo = 0;
        push_expected();
        b0 = busy_tot; e0 = edge_tot; d0 = done_tot; a0 = acc_tot;
        pulse_start();
        fork
            begin
                for (int k = 0; k < NB; k++) begin
                    bus.byte_in    = pat;
                    bus.byte_valid = (k != stall_k);
                    cyc = 0;
                    @(negedge clk);
                    while (!bus.byte_ready && cyc < 2000) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (cyc >= 2000) tmo++;
                    if (k == stall_k) begin
                        for (int s = 0; s < 10; s++) begin
                            check("stall_prog_clk", bus.prog_clk, 1'b0);
                            check("stall_prog_en", bus.prog_en, 1'b1);
                            @(posedge clk);
                            #1;
                            if (s < 9) @(negedge clk);
                        end
                        bus.byte_valid = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.byte_valid = 1'b0;
            end
            begin
                if (extra_start) begin
                    repeat (8) @(posedge clk);
                    #1 bus.start = 1'b1;
                    @(posedge clk); #1 bus.start = 1'b0;
                    repeat (189) @(posedge clk);
                    #1 bus.start = 1'b1;
                    @(posedge clk); #1 bus.start = 1'b0;
                end
            end
        join
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) tmo++;
        repeat (3) @(negedge clk);
        check("timeout", tmo, 0);
        check("busy_cycles", busy_tot - b0, exp_busy);
        check("prog_clk_edges", edge_tot - e0, CL);
        check("done_cycles", done_tot - d0, 1);
        check("bytes_accepted", acc_tot - a0, NB);
        check("rd_all_seen", exp_q.size(), 0);
        check("chain_contents", chain, pat_chain(pat));
        prev_pat   = pat;
        prev_known = 1'b1;
    endtask

    initial begin
        int e0, cyc;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", bus.byte_ready, 1'b0);
        check("rst_prog_in", bus.prog_in, 1'b0);
        check("rst_prog_clk", bus.prog_clk, 1'b0);
        check("rst_prog_en", bus.prog_en, 1'b0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_load(8'hA5, -1, 1'b0, 372);
        run_load(8'h3C, -1, 1'b0, 372);
        run_load(8'h3C, 5, 1'b0, 382);
        run_load(8'hA5, -1, 1'b1, 372);

        // Abort: reset while prog_clk is high on the 50th rising edge.
        push_expected();
        e0 = edge_tot;
        pulse_start();
        bus.byte_in    = 8'h3C;
        bus.byte_valid = 1'b1;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if ((edge_tot - e0 >= 49 && bus.prog_clk) || cyc >= 2000) break;
        end
        check("abort_reached", cyc < 2000, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_prog_clk", bus.prog_clk, 1'b0);
        check("abort_prog_en", bus.prog_en, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_byte_ready", bus.byte_ready, 1'b0);
        check("abort_rd_data", bus.rd_data, 8'h00);
        bus.byte_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_known = 1'b0;
        repeat (2) @(posedge clk);
        run_load(8'h3C, -1, 1'b0, 372);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
